dm_responder: RTL
=================

Name: dm_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data accesses: the target end of the load/store request interface.
- Accepts one word request at a time over a valid/ready handshake.
- Holds the data array internally and inserts a configurable wait latency.
- Returns read data or a write acknowledgement over a second valid/ready handshake, with an error flag for misaligned or out-of-range addresses.

Parameters:
- DEPTH_LOG2, 10, log2 of word count in the data array (1024 words).
- LATENCY, 2, wait cycles between request acceptance and access commit; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables for store; bit i covers data bits [8i+7:8i]; ignored for load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0; wait counter=0.
  - All array words are cleared to 0 at that edge.
  - Reset overrides every other input, including a request or response handshake in the same cycle.
- States: IDLE, WAIT, RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, latch we, be, addr and wdata.
  - If LATENCY==0, go to RESP and commit the access at that edge.
  - Otherwise go to WAIT with counter=LATENCY.
  - With req_valid==0, stay in IDLE.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - At the edge where counter==1, commit the access and go to RESP.
- Latency: resp_valid is high in the cycle after edge E0+LATENCY, where E0 is the accepting edge.
- Commit rules:
  - Word index = (addr-BASE_ADDR)>>2.
  - err = (addr[1:0]!=0) or addr<BASE_ADDR or addr>=BASE_ADDR+4*2^DEPTH_LOG2.
  - On err: no array change; resp_rdata=0; resp_err=1.
  - Load: resp_rdata = array word as it stands at the commit edge.
  - Store: each byte lane with be[i]=1 is replaced by wdata; other lanes are kept. resp_rdata=0.
  - Store with be==0: no change, no error.
- RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_err stay stable until the handshake.
  - On an edge with resp_ready: resp_valid<=0, resp_rdata<=0, resp_err<=0, go to IDLE. req_ready is 1 in the following cycle.
  - Without resp_ready, hold indefinitely (backpressure).
  - A new request cannot be accepted in the same edge as the response handshake; minimum spacing between acceptances is LATENCY+2 cycles.
- Ordering: a load after a store to the same word always observes the store, since there is one outstanding request.
- Reset mid-operation (WAIT or RESP): the request is abandoned with no response, the array is cleared, and the block returns to IDLE.
- Inputs other than req_valid are don't-care outside the accepting edge, because latched copies are used.

Test Plan:
- Reset low 1 cycle, then high -> req_ready=1, resp_valid=0, busy=0; load from 0x0000_0010 returns rdata=0, err=0.
- LATENCY=2: store be=4'hF, addr 0x0000_0040, wdata 0xDEADBEEF accepted at cycle 0 -> resp_valid first high in cycle 3, rdata=0, err=0. Then load 0x40 -> rdata=0xDEADBEEF.
- Partial store be=4'b0101, wdata 0x11223344 onto 0xDEADBEEF at 0x40 -> subsequent load returns 0xDE22BE44.
- Load addr 0x0000_0042 -> err=1, rdata=0. Load addr 0x0000_1000 (DEPTH_LOG2=10) -> err=1, array unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout. resp_ready=1 -> next cycle resp_valid=0, req_ready=1.
- Store accepted, then reset low during WAIT -> no response appears; a later load at that address returns 0; LATENCY=0 build gives resp_valid in the cycle after acceptance.

Source files
------------

// File: rtl/dm_responder_if.sv
// Request/response bus between a MEM-stage requester and the data memory responder.
// Two independent valid/ready channels: word request in, read data / write ack out.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data memory responder: one outstanding word access, fixed wait latency,
// byte-lane stores, error response for misaligned or out-of-range addresses.
module dm_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus,
  output logic          busy
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;

  // With zero latency the access commits on the accepting edge, so it must use
  // the live bus fields rather than the latched copies.
  always_comb begin
    w_accept = (r_state == S_IDLE) && bus.req_valid;
    w_commit = (LATENCY == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    w_we     = (r_state == S_IDLE) ? bus.req_we    : r_we;
    w_be     = (r_state == S_IDLE) ? bus.req_be    : r_be;
    w_addr   = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
    w_wdata  = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
    w_off    = w_addr - BASE_ADDR;
    w_idx    = DEPTH_LOG2'(w_off >> 2);
    w_err    = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) || ({1'b0, w_addr} >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_be         <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_be        <= bus.req_be;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LATENCY == 0) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Errored accesses leave the array alone and return zero data.
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
        if (!w_err && w_we) begin
          for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign busy           = r_busy;

endmodule
